mvu_thresholding_axi: RTL and testbench
=======================================

// Module: mvu_thresholding_axi
// PURPOSE
//  Downstream stage of the MVU/VVU AXI wrapper: consumes PE-wide accumulator vectors and emits
//  O_BITS-wide quantised activations per lane by multi-threshold comparison.
//  Per-channel thresholds are held in on-chip memory, indexed by a neuron-fold counter.
//  Fully pipelined, one vector/cycle, AXI-Stream backpressure on both sides.
// PARAMETERS
//  MH          64  matrix height = channel count; MH % PE == 0 required
//  PE          4   lanes per input beat; matches upstream PE
//  ACCU_WIDTH  16  accumulator width per lane (two's complement if SIGNED_ACCU)
//  O_BITS      4   output width per lane; N_THRES = 2**O_BITS-1 thresholds per channel
//  SIGNED_ACCU 1   1: signed compare of accumulator and thresholds; 0: unsigned
//  THRES_INIT  ""  $readmemh file, one line per channel c (0..MH-1), N_THRES*ACCU_WIDTH bits
//  Derived:    NF=MH/PE; IN_W=PE*ACCU_WIDTH; OUT_W=PE*O_BITS; both byte-aligned (_BA) on AXIS
// PORTS
//  ap_clk                in   1              clock
//  ap_rst_n              in   1              asynchronous, active-low reset
//  s_axis_input_tdata    in   IN_W_BA        lane p at [p*ACCU_WIDTH +: ACCU_WIDTH]
//  s_axis_input_tvalid   in   1
//  s_axis_input_tready   out  1
//  m_axis_output_tdata   out  OUT_W_BA       lane p at [p*O_BITS +: O_BITS]; pad bits 0
//  m_axis_output_tvalid  out  1
//  m_axis_output_tready  in   1
//  cfg_we                in   1              threshold write strobe
//  cfg_addr              in   clog2(MH)      channel c; stored at fold c/PE, lane c%PE
//  cfg_data              in   N_THRES*ACCU_WIDTH  thresholds t[0..N_THRES-1], t[i] at [i*ACCU_WIDTH+:]
// BEHAVIOUR
//  - Reset (async assert, sync deassert internally): m_axis_output_tvalid=0, tdata=0,
//    s_axis_input_tready=1 one cycle after deassert, fold counter=0. Threshold memory NOT reset.
//  - Pipeline: S1 registers accumulators + fold index and issues registered memory read;
//    S2 compares and registers output. Global enable en = !m_tvalid || m_tready; s_tready = en.
//  - Latency: beat accepted at edge t appears on m_axis_output at edge t+2 when unstalled.
//  - Stall: tdata/tvalid held stable while tvalid && !tready; no beat dropped or duplicated.
//  - Fold counter: increments on each accepted input beat; wraps NF-1 -> 0 (next pixel).
//    NF==1: counter constant 0.
//  - Output per lane: y = count of i with acc >= t[i] (compare per SIGNED_ACCU); range 0..N_THRES.
//    Thresholds need not be sorted; count semantics hold regardless.
//  - Mid-reset during streaming: all in-flight beats discarded, counter restarts at fold 0.
//  - Simultaneous cfg write and read of same fold: read returns old data (read-first);
//    new data visible to beats accepted on later cycles.
//  - cfg_addr >= MH: write ignored.
// CONFIGURATION
//  Macro THRESH_CFG_WRITE_EN:
//   defined:   cfg_* ports functional; run-time threshold updates as above.
//   undefined: cfg_* ports present but ignored; memory is ROM from THRES_INIT only.
//   Both:      THRES_INIT applied if non-empty; else memory contents undefined until written.
// TESTING
//  1 MH=4,PE=2,O_BITS=2,signed; ch0 t={-4,0,4}; lane0 acc -5,-4,0,3,4 over 5 pixels
//    -> y=0,1,2,2,3.
//  2 NF=2 fold check: ch0 t={0,0,0}, ch2 t={10,10,10}; acc=5 on both beats of a pixel
//    -> lane0 y=3 then y=0; repeats next pixel.
//  3 Backpressure: 20 beats, tready random 50% -> output sequence = golden model, no
//    drops/dups; tdata stable while stalled.
//  4 Throughput: tvalid/tready held 1 -> one output per cycle; first output 2 cycles after first accept.
//  5 Reset after 3 of 4 fold beats -> tvalid=0 within reset; next beat uses fold 0 thresholds.
//  6 THRESH_CFG_WRITE_EN: write ch1 {1,2,3} in same cycle beat for fold 0 accepted
//    -> that beat old thresholds, next pixel new (acc=2 -> y=2); without macro: write has no effect.

Source files
------------

// File: rtl/mvu_thresholding_axi_if.sv
// AXI-Stream channel bundle (tdata/tvalid/tready) shared by the threshold
// stage's input and output ports. W is the byte-aligned tdata width.
interface mvu_thresholding_axi_if #(
    parameter int W = 8
) ();
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/mvu_thresholding_axi.sv
// mvu_thresholding_axi
// Multi-threshold quantiser behind the MVU/VVU stream. It accepts one beat per
// cycle with PE accumulators. Each lane is compared against the N_THRES
// thresholds of its channel, and the number of thresholds met is emitted as
// an O_BITS code.
// Channel of lane p at fold f is f*PE + p. The fold counter steps once per
// accepted beat.
// Pipeline: A = accumulators + threshold read, B = compare, then the output
// register. An accepted beat leaves two edges after acceptance. One global
// enable stalls all three stages together.
// Optional build macro THRESH_CFG_WRITE_EN enables the cfg_* write port.
// Without it the threshold memory is a ROM loaded from THRES_INIT.
module mvu_thresholding_axi #(
    parameter int MH          = 64,
    parameter int PE          = 4,
    parameter int ACCU_WIDTH  = 16,
    parameter int O_BITS      = 4,
    parameter int SIGNED_ACCU = 1,
    parameter     THRES_INIT  = "",
    localparam int N_THRES    = (1 << O_BITS) - 1,
    localparam int THR_W      = N_THRES * ACCU_WIDTH,
    localparam int ADDR_W     = (MH > 1) ? $clog2(MH) : 1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    mvu_thresholding_axi_if.slave       s_axis_input,
    mvu_thresholding_axi_if.master      m_axis_output,
    input  logic                        cfg_we,
    input  logic [ADDR_W-1:0]           cfg_addr,
    input  logic [THR_W-1:0]            cfg_data
);
    localparam int NF       = MH / PE;
    localparam int FOLD_W   = (NF > 1) ? $clog2(NF) : 1;
    localparam int IN_W     = PE * ACCU_WIDTH;
    localparam int OUT_W    = PE * O_BITS;
    localparam int OUT_W_BA = ((OUT_W + 7) / 8) * 8;

    // Per-channel threshold vectors, t[i] at [i*ACCU_WIDTH +: ACCU_WIDTH]; never reset.
    logic [THR_W-1:0]    thres_mem [MH];

    logic                rst_n_sync_r;
    logic                en_s;
    logic                accept_s;
    logic [FOLD_W-1:0]   fold_r;

    logic                a_valid_r;
    logic [IN_W-1:0]     a_acc_r;
    logic [THR_W-1:0]    a_thr_r [PE];

    logic                b_valid_r;
    logic [OUT_W-1:0]    b_y_r;

    logic                m_valid_r;
    logic [OUT_W_BA-1:0] m_data_r;

    // Count of thresholds met by one accumulator; order of thresholds is irrelevant.
    function automatic logic [O_BITS-1:0] thresh_count(
        input logic [ACCU_WIDTH-1:0] acc,
        input logic [THR_W-1:0]      thr
    );
        int unsigned cnt;
        logic        ge;
        cnt = 0;
        for (int i = 0; i < N_THRES; i++) begin
            if (SIGNED_ACCU != 0) begin
                ge = $signed(acc) >= $signed(thr[i*ACCU_WIDTH +: ACCU_WIDTH]);
            end else begin
                ge = acc >= thr[i*ACCU_WIDTH +: ACCU_WIDTH];
            end
            cnt = cnt + int'(ge);
        end
        return O_BITS'(cnt);
    endfunction

    // Memory address of the channel served by lane p at fold f.
    function automatic logic [ADDR_W-1:0] chan_addr(input logic [FOLD_W-1:0] f, input int p);
        return ADDR_W'(int'(f) * PE + p);
    endfunction

`ifdef THRESH_CFG_WRITE_EN
    // Run-time threshold write; a stage-A read on the same edge still sees the old vector.
    always_ff @(posedge ap_clk) begin
        if (cfg_we && ({1'b0, cfg_addr} < (ADDR_W + 1)'(MH))) begin
            thres_mem[cfg_addr] <= cfg_data;
        end
    end
`else
    logic cfg_unused_s;
    assign cfg_unused_s = ^{cfg_we, cfg_addr, cfg_data};
`endif

    // Reset release is taken synchronously so input readiness appears one cycle after deassert.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_n_sync_r <= 1'b0;
        end else begin
            rst_n_sync_r <= 1'b1;
        end
    end

    // Global pipeline enable and input handshake.
    always_comb begin
        en_s     = !m_valid_r || m_axis_output.tready;
        accept_s = s_axis_input.tvalid && rst_n_sync_r && en_s;
    end

    assign s_axis_input.tready  = rst_n_sync_r && en_s;
    assign m_axis_output.tvalid = m_valid_r;
    assign m_axis_output.tdata  = m_data_r;

    // Neuron-fold counter: one step per accepted beat, wrapping to fold 0 at the pixel end.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            fold_r <= '0;
        end else if (accept_s) begin
            if (fold_r == FOLD_W'(NF - 1)) begin
                fold_r <= '0;
            end else begin
                fold_r <= fold_r + FOLD_W'(1);
            end
        end
    end

    // Stage A: capture accumulators and read this fold's thresholds.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_valid_r <= 1'b0;
            a_acc_r   <= '0;
            for (int p = 0; p < PE; p++) begin
                a_thr_r[p] <= '0;
            end
        end else if (en_s) begin
            a_valid_r <= accept_s;
            a_acc_r   <= s_axis_input.tdata[IN_W-1:0];
            for (int p = 0; p < PE; p++) begin
                a_thr_r[p] <= thres_mem[chan_addr(fold_r, p)];
            end
        end
    end

    // Stage B: per-lane multi-threshold compare.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            b_valid_r <= 1'b0;
            b_y_r     <= '0;
        end else if (en_s) begin
            b_valid_r <= a_valid_r;
            for (int p = 0; p < PE; p++) begin
                b_y_r[p*O_BITS +: O_BITS] <= thresh_count(a_acc_r[p*ACCU_WIDTH +: ACCU_WIDTH], a_thr_r[p]);
            end
        end
    end

    // Output register; the byte-alignment pad bits stay zero.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
        end else if (en_s) begin
            m_valid_r <= b_valid_r;
            m_data_r  <= OUT_W_BA'(b_y_r);
        end
    end
endmodule

// File: tb/tb_mvu_thresholding_axi.sv
// Bench for mvu_thresholding_axi with MH=8, PE=2, ACCU_WIDTH=16, O_BITS=2, signed.
// This gives NF=4, 3 thresholds per channel and a 32-bit input / 8-bit output stream.
// Fixed vectors come from a table of hand-derived codes.
// Random traffic is scored against a count-of-thresholds model and an expected-output queue.
module tb_mvu_thresholding_axi;
    localparam int MH = 8;
    localparam int PE = 2;
    localparam int NF = MH / PE;

    typedef struct {
        logic [15:0] a0;
        logic [15:0] a1;
        logic [1:0]  y0;
        logic [1:0]  y1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [47:0] cfg_data;

    mvu_thresholding_axi_if #(.W(32)) s_if ();
    mvu_thresholding_axi_if #(.W(8))  m_if ();

    mvu_thresholding_axi #(
        .MH(MH), .PE(PE), .ACCU_WIDTH(16), .O_BITS(2), .SIGNED_ACCU(1)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n),
        .s_axis_input(s_if), .m_axis_output(m_if),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          thr_m [MH][3];
    int          fold_m = 0;
    logic [7:0]  exp_q [$];
    vec_t        tbl [$];
    int          cyc = 0;
    logic        in_acc, out_seen, stall_prev;
    logic [7:0]  stall_data;
    logic        ovr_en;
    logic [7:0]  ovr_val;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int ycount(input int ch, input int acc);
        int cnt = 0;
        for (int i = 0; i < 3; i++) if (acc >= thr_m[ch][i]) cnt++;
        return cnt;
    endfunction

    // One clock: score outputs and log accepted beats at the negedge, then pass the posedge.
    task automatic step();
        logic [7:0] e;
        int a0, a1;
        @(negedge clk);
        if (stall_prev) begin
            chk("stall_valid", {31'd0, m_if.tvalid}, 32'd1);
            chk("stall_data", {24'd0, m_if.tdata}, {24'd0, stall_data});
        end
        stall_prev = m_if.tvalid && !m_if.tready;
        stall_data = m_if.tdata;
        out_seen = m_if.tvalid && m_if.tready;
        if (out_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %0h want none (cycle %0d)", m_if.tdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {24'd0, m_if.tdata}, {24'd0, e});
            end
        end
        in_acc = s_if.tvalid && s_if.tready;
        if (in_acc) begin
            a0 = int'($signed(s_if.tdata[15:0]));
            a1 = int'($signed(s_if.tdata[31:16]));
            if (ovr_en) e = ovr_val;
            else e = {4'd0, 2'(ycount(2*fold_m + 1, a1)), 2'(ycount(2*fold_m, a0))};
            exp_q.push_back(e);
            fold_m = (fold_m + 1) % NF;
        end
`ifdef THRESH_CFG_WRITE_EN
        if (cfg_we) begin
            for (int i = 0; i < 3; i++) thr_m[cfg_addr][i] = int'($signed(cfg_data[i*16 +: 16]));
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_thr(input int ch, input int t0, input int t1, input int t2);
`ifdef THRESH_CFG_WRITE_EN
        s_if.tvalid = 1'b0;
        cfg_we = 1'b1;
        cfg_addr = 3'(ch);
        cfg_data = {16'(t2), 16'(t1), 16'(t0)};
        step();
        cfg_we = 1'b0;
`else
        dut.thres_mem[ch] = {16'(t2), 16'(t1), 16'(t0)};
        thr_m[ch][0] = t0;
        thr_m[ch][1] = t1;
        thr_m[ch][2] = t2;
`endif
    endtask

    task automatic drain();
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) step();
        chk("drain_left", exp_q.size(), 32'd0);
        repeat (3) step();
    endtask

    // Apply every queued table row in order (full throughput) and compare against its codes.
    task automatic run_table();
        int g;
        m_if.tready = 1'b1;
        ovr_en = 1'b1;
        foreach (tbl[k]) begin
            s_if.tdata = {tbl[k].a1, tbl[k].a0};
            s_if.tvalid = 1'b1;
            ovr_val = {4'd0, tbl[k].y1, tbl[k].y0};
            g = 0;
            do begin step(); g++; end while (!in_acc && g < 50);
            if (!in_acc) begin
                checks++;
                errors++;
                $display("FAIL table_accept got 0 want 1 (row %0d)", k);
            end
        end
        ovr_en = 1'b0;
        tbl.delete();
        drain();
    endtask

    task automatic fillers_acc5();
        tbl.push_back(vec_t'{16'sd5, 16'sd5, 2'd0, 2'd3});
        tbl.push_back(vec_t'{16'sd5, 16'sd5, 2'd2, 2'd2});
        tbl.push_back(vec_t'{16'sd5, 16'sd5, 2'd1, 2'd3});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] t1_a0 [5];
        logic [15:0] t1_a1 [5];
        logic [1:0]  t1_y0 [5];
        logic [1:0]  t1_y1 [5];
        int sent, g, nout, acc_c, out_c, last_c;

        rst_n = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = 32'd0;
        m_if.tready = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 48'd0;
        ovr_en = 1'b0;
        ovr_val = 8'd0;
        stall_prev = 1'b0;
        stall_data = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        set_thr(0, -4, 0, 4);
        set_thr(1, -10, 0, 10);
        set_thr(2, 10, 10, 10);
        set_thr(3, -1, -1, -1);
        set_thr(4, 100, -100, 0);
        set_thr(5, -32768, 0, 32767);
        set_thr(6, 5, 6, 7);
        set_thr(7, 0, 1, 2);

        // Reset state and synchronous release of input readiness.
        @(negedge clk);
        chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_tdata", {24'd0, m_if.tdata}, 32'd0);
        chk("rst_tready", {31'd0, s_if.tready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_tready_early", {31'd0, s_if.tready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_tready", {31'd0, s_if.tready}, 32'd1);
        @(posedge clk);
        #1;

        // Basic quantisation on ch0 {-4,0,4} / ch1 {-10,0,10}, one pixel per table row.
        t1_a0 = '{-16'sd5, -16'sd4, 16'sd0, 16'sd3, 16'sd4};
        t1_a1 = '{-16'sd11, -16'sd10, 16'sd0, 16'sd9, 16'sd10};
        t1_y0 = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        t1_y1 = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(vec_t'{t1_a0[k], t1_a1[k], t1_y0[k], t1_y1[k]});
            tbl.push_back(vec_t'{16'sd0, 16'sd0, 2'd0, 2'd3});
            tbl.push_back(vec_t'{16'sd0, 16'sd0, 2'd2, 2'd2});
            tbl.push_back(vec_t'{16'sd0, 16'sd0, 2'd0, 2'd1});
        end
        run_table();

        // Fold selection: same accumulator 5 hits different channels per fold, two pixels.
        set_thr(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(vec_t'{16'sd5, 16'sd5, 2'd3, 2'd2});
            fillers_acc5();
        end
        run_table();

        // Random backpressure on both sides, scored by the model.
        sent = 0;
        g = 0;
        s_if.tvalid = 1'b0;
        while (sent < 20 && g < 600) begin
            if (!s_if.tvalid && $urandom_range(0, 3) != 0) begin
                s_if.tvalid = 1'b1;
                s_if.tdata = $urandom;
            end
            m_if.tready = ($urandom_range(0, 1) == 1);
            step();
            if (in_acc) begin
                sent++;
                s_if.tvalid = 1'b0;
            end
            g++;
        end
        chk("bp_sent", sent, 32'd20);
        drain();

        // Throughput and latency with tvalid/tready held high.
        sent = 0;
        nout = 0;
        acc_c = 0;
        out_c = 0;
        last_c = 0;
        m_if.tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_if.tvalid = (sent < 8);
            s_if.tdata = $urandom;
            step();
            if (in_acc) begin
                if (sent == 0) acc_c = cyc;
                sent++;
            end
            if (out_seen) begin
                if (nout == 0) out_c = cyc;
                nout++;
                last_c = cyc;
            end
        end
        chk("tp_latency", out_c - acc_c, 32'd3);
        chk("tp_count", nout, 32'd8);
        chk("tp_burst", last_c - out_c, 32'd7);
        drain();

        // Reset after 3 of 4 fold beats: in-flight beats dropped, fold restarts at 0.
        for (int k = 0; k < 3; k++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata = $urandom;
            step();
        end
        s_if.tvalid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        fold_m = 0;
        stall_prev = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("mid_rst_tdata", {24'd0, m_if.tdata}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        tbl.push_back(vec_t'{16'sd5, 16'sd5, 2'd3, 2'd2});
        fillers_acc5();
        run_table();

        // Same-cycle cfg write of ch1 {1,2,3} while the fold-0 beat is accepted.
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata = 32'd0;
        cfg_we = 1'b1;
        cfg_addr = 3'd1;
        cfg_data = {16'sd3, 16'sd2, 16'sd1};
        ovr_en = 1'b1;
        ovr_val = {4'd0, 2'd2, 2'd3};
        step();
        chk("cfg_beat_accept", {31'd0, in_acc}, 32'd1);
        cfg_we = 1'b0;
        ovr_en = 1'b0;
        fillers_acc5();
        tbl.push_back(vec_t'{16'sd5, 16'sd2, 2'd3, 2'd2});
        fillers_acc5();
`ifdef THRESH_CFG_WRITE_EN
        tbl.push_back(vec_t'{16'sd5, -16'sd5, 2'd3, 2'd0});
`else
        tbl.push_back(vec_t'{16'sd5, -16'sd5, 2'd3, 2'd1});
`endif
        fillers_acc5();
        run_table();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
